// File: rtl/jam_cost_eval.sv
// jam_cost_eval
//   Scores worker->job permutations from the upstream permutation generator.
//   For each permutation the eight costs are fetched from the external cost
//   table, one worker per cycle, and summed. The block keeps the lowest total
//   seen and the number of permutations that hit it. When the generator flags
//   the last permutation, Valid is raised and held.
//
// Ports
//   CLK, RST        clock, asynchronous active-high reset
//   sort[23:0]      current permutation; job of worker w = sort[23-3w -: 3]
//   changed         one-cycle strobe: new permutation presented on sort
//   finish          level: permutation on sort is the last one
//   next            one-cycle request for the next permutation
//   W, J            cost table worker/job address (0 outside accumulation)
//   Cost            cost table data, combinational in W/J
//   MinCost         lowest total seen so far
//   MatchCount      permutations whose total equals MinCost (saturating)
//   Valid           final result available, held until reset
module jam_cost_eval #(
    parameter int unsigned COST_W = 7,
    parameter int unsigned SUM_W  = 10,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [23:0]       sort,
    input  logic              changed,
    input  logic              finish,
    output logic              next,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [COST_W-1:0] Cost,
    output logic [SUM_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  MatchCount,
    output logic              Valid
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    // StInit is the reset state; the identity permutation is already on sort,
    // so accumulation begins on the first edge after reset is released.
    typedef enum logic [2:0] {
        StInit,
        StAcc,
        StCmp,
        StReq,
        StWait,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       w_q, w_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [23:0]      sort_shifted;
    logic [2:0]       job;

    // Bring the field of worker w_q to the top three bits.
    always_comb begin
        sort_shifted = sort << ({2'b00, w_q} * 5'd3);
        job          = sort_shifted[23:21];
    end

    // State register and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StInit;
            w_q     <= 3'd0;
            sum_q   <= '0;
            min_q   <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  state_d = StAcc;
            StAcc:   if (w_q == 3'd7) state_d = StCmp;
            StCmp:   state_d = finish ? StDone : StReq;
            StReq:   state_d = StWait;
            StWait: begin
                if (changed) begin
                    state_d = StAcc;
                end else if (finish) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StInit;
        endcase
    end

    // Datapath next-state: accumulate, compare, clear on entry to accumulation.
    always_comb begin
        w_d   = w_q;
        sum_d = sum_q;
        min_d = min_q;
        cnt_d = cnt_q;
        case (state_q)
            StInit: begin
                w_d   = 3'd0;
                sum_d = '0;
            end
            StAcc: begin
                sum_d = sum_q + SUM_W'(Cost);
                w_d   = w_q + 3'd1;  // wraps to 0 after worker 7
            end
            StCmp: begin
                if (sum_q < min_q) begin
                    min_d = sum_q;
                    cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (sum_q == min_q) begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWait: begin
                if (changed) begin
                    w_d   = 3'd0;
                    sum_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs.
    always_comb begin
        W          = 3'd0;
        J          = 3'd0;
        next       = 1'b0;
        Valid      = 1'b0;
        MinCost    = min_q;
        MatchCount = cnt_q;
        case (state_q)
            StAcc: begin
                W = w_q;
                J = job;
            end
            StReq:   next  = 1'b1;
            StDone:  Valid = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: doc/jam_cost_eval.md
# jam_cost_eval

Downstream consumer of the permutation generator in the job-assignment datapath. It takes each 8-entry worker→job permutation and fetches the eight costs from the external cost table one per cycle. It accumulates the total, then tracks the minimum total and how many permutations hit it. After the generator signals that the last permutation has been presented, it raises `Valid` with the final result.

## Interface
Parameters:
- `COST_W`, default 7: cost table entry width.
- `SUM_W`, default 10: accumulator and `MinCost` width. It must hold 8·(2^COST_W−1).
- `CNT_W`, default 4: `MatchCount` width. The count saturates.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `sort`  in  24  current permutation. Job of worker w = `sort[23-3w -: 3]`, for w = 0..7.
- `changed`  in  1  one-cycle strobe from the generator: a new permutation is on `sort`.
- `finish`  in  1  level from the generator: the permutation on `sort` is the last one.
- `next`  out  1  one-cycle request to the generator for the next permutation.
- `W`  out  3  cost table worker address.
- `J`  out  3  cost table job address.
- `Cost`  in  COST_W  cost table data. It is combinational in `W`/`J` and valid in the same cycle.
- `MinCost`  out  SUM_W  lowest total seen so far.
- `MatchCount`  out  CNT_W  number of permutations whose total equals `MinCost`.
- `Valid`  out  1  final result available. Held high.

## Operation
States:
- **ACC**
  - Entered on the first edge after `RST` falls, because the identity permutation is already on `sort`.
  - 3-bit worker counter w goes 0→7; `W`=w, `J`=job of worker w.
  - Each cycle: sum ← sum + `Cost`. sum is cleared on entry.
  - After w=7 → CMP.
- **CMP** (1 cycle)
  - If sum < `MinCost`: `MinCost`←sum, `MatchCount`←1.
  - Else if sum == `MinCost`: `MatchCount`←`MatchCount`+1, saturating at 2^CNT_W−1.
  - Else: no change.
  - Next state: if `finish`=1 → DONE, else → REQ.
- **REQ** (1 cycle): `next`=1 → WAIT.
- **WAIT**
  - `changed`=1 → ACC (w=0, sum cleared).
  - `finish`=1 and no `changed` → DONE.
  - Otherwise stay.
- **DONE**: `Valid`=1. Terminal until `RST`.

Outputs:
- `W`/`J` hold 0 outside ACC.
- `sort` is sampled combinationally during ACC. The generator holds it stable from `changed` until the next `next`.
- `next` is asserted only in REQ and never in DONE.

Arithmetic:
- sum is unsigned SUM_W bits. The SUM_W rule guarantees it cannot overflow.
- All comparisons are unsigned.

## Timing
Reset values (asynchronous):
- state = ACC-pending, so the first ACC cycle is the first edge after `RST` deasserts.
- sum = 0, w = 0.
- `MinCost` = all ones (1023).
- `MatchCount` = 0, `Valid` = 0, `next` = 0, `W` = 0, `J` = 0.

Latency per permutation:
- 8 cycles ACC + 1 CMP + 1 REQ + WAIT.
- WAIT is at least 1 cycle, because `changed` arrives at the earliest on the edge after `next`.

Other timing rules:
- `changed` arriving outside WAIT is ignored. The generator must not produce one unsolicited.
- `finish` is sampled in CMP. The generator must assert it no later than 9 cycles after presenting the last permutation.
- `Valid` rises on the edge after the CMP (or WAIT) cycle that saw `finish`. `MinCost`/`MatchCount` are final on that same edge.
- `RST` mid-ACC/WAIT/DONE: all state returns to reset values immediately, and evaluation restarts at ACC with the permutation on `sort`.
- Ties at saturation: `MatchCount` stays at the maximum and `MinCost` is unchanged.

## Test plan
- Cost[w][j] = 0 when w==j, else 100. Full 40320-permutation run with the real generator → `MinCost`=0, `MatchCount`=1, `Valid`=1 after the last CMP.
- All costs = 1 → `MinCost`=8, `MatchCount` saturates at 15.
- Scripted upstream, two permutations, totals 50 then 50, `finish` with the second → `MinCost`=50, `MatchCount`=2. `next` pulses exactly once, in the cycle after the first CMP.
- Scripted upstream delaying `changed` by 5 cycles after `next` → `W`/`J` stay 0 during WAIT. ACC starts on the edge after `changed`, and `J` matches the `sort` fields in order.
- `finish` asserted while in WAIT with no `changed` → DONE next edge, `Valid`=1, `next` never reasserts.
- `RST` pulsed during ACC cycle w=4 of the third permutation → outputs return to reset values. The run restarts and yields the same final `MinCost`/`MatchCount` as an uninterrupted run.
